// File: rtl/drum_pkg.sv
// Shared configuration, stage payload types and the DRUM truncation helper.
// All stage structs are sized from the DRUM_K/DRUM_N/DRUM_M defaults below;
// the drum_pipe_mult parameters default to the same values.
package drum_pkg;

    localparam int unsigned DRUM_K = 6;
    localparam int unsigned DRUM_N = 16;
    localparam int unsigned DRUM_M = 16;

    localparam int unsigned LA  = $clog2(DRUM_N);
    localparam int unsigned LB  = $clog2(DRUM_M);
    localparam int unsigned SW  = $clog2(DRUM_M) + 1;
    localparam int unsigned MW  = (DRUM_N > DRUM_M) ? DRUM_N : DRUM_M;
    localparam int unsigned LW  = $clog2(MW);
    localparam int unsigned PW2 = 2 * DRUM_K;
    localparam int unsigned RW  = DRUM_N + DRUM_M;

    // Truncated operand and its left-shift amount
    typedef struct packed {
        logic [DRUM_K-1:0] mm;
        logic [SW-1:0]     p;
    } trunc_t;

    // S1 -> S2: magnitudes, result sign, leading-one positions
    typedef struct packed {
        logic [DRUM_N-1:0] mag_a;
        logic [DRUM_M-1:0] mag_b;
        logic              sign;
        logic [LA-1:0]     k1;
        logic [LB-1:0]     k2;
    } s1_t;

    // S2 -> S3: core product, total shift, sign, exact flag
    typedef struct packed {
        logic [PW2-1:0] prod;
        logic [SW-1:0]  sh;
        logic           sign;
        logic           exact;
    } s2_t;

    // S3 output slot
    typedef struct packed {
        logic [RW-1:0] r;
        logic          exact;
    } s3_t;

    // Keep K bits from the leading one down; the dropped tail is replaced by a
    // forced LSB of 1, which centres the truncation error around zero.
    function automatic trunc_t drum_trunc(input logic [MW-1:0] mag, input logic [LW-1:0] k);
        trunc_t       t;
        logic [LW-1:0] p;
        t = '0;
        p = '0;
        if (k > LW'(DRUM_K - 1)) begin
            p    = k - LW'(DRUM_K - 1);
            t.mm = DRUM_K'(mag >> p) | DRUM_K'(1);
            t.p  = SW'(p);
        end else begin
            t.mm = DRUM_K'(mag);
            t.p  = '0;
        end
        return t;
    endfunction

endpackage

// File: rtl/drum_pipe_mult_if.sv
// Streaming bus of the DRUM multiplier.
// master: drives in_valid/signed_mode/a/b/out_ready, observes in_ready/out_valid/r/exact.
// slave : the multiplier side of the same signals.
interface drum_pipe_mult_if
    import drum_pkg::*;
#(
    parameter int unsigned N = DRUM_N,
    parameter int unsigned M = DRUM_M
);
    logic           in_valid;
    logic           in_ready;
    logic           signed_mode;
    logic [N-1:0]   a;
    logic [M-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [N+M-1:0] r;
    logic           exact;

    modport master (
        output in_valid, signed_mode, a, b, out_ready,
        input  in_ready, out_valid, r, exact
    );

    modport slave (
        input  in_valid, signed_mode, a, b, out_ready,
        output in_ready, out_valid, r, exact
    );
endinterface

// File: rtl/drum_lod_enc.sv
// Leading-one detector with binary position encode.
// x     : input vector (W bits)
// pos_c : index of the most significant set bit of x, 0 when x is zero
module drum_lod_enc #(
    parameter  int unsigned W  = 16,
    localparam int unsigned PW = $clog2(W)
) (
    input  logic [W-1:0]  x,
    output logic [PW-1:0] pos_c
);

    // Upward scan: the last set bit seen is the leading one
    always_comb begin
        pos_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (x[i]) begin
                pos_c = PW'(i);
            end
        end
    end

endmodule

// File: rtl/drum_pipe_mult.sv
// Three-stage pipelined DRUM approximate multiplier, throughput one per cycle.
// clk, rst : rising-edge clock, asynchronous active-high reset
// bus      : slave side of drum_pipe_mult_if
//            in_valid/in_ready/signed_mode/a/b  - operand stream
//            out_valid/out_ready/r/exact         - result stream (r/exact registered)
module drum_pipe_mult
    import drum_pkg::*;
#(
    parameter int unsigned K = DRUM_K,
    parameter int unsigned N = DRUM_N,
    parameter int unsigned M = DRUM_M
) (
    input  logic             clk,
    input  logic             rst,
    drum_pipe_mult_if.slave  bus
);

    logic s1_v, s2_v, s3_v;
    s1_t  s1_q, s1_c;
    s2_t  s2_q, s2_c;
    s3_t  s3_q, s3_c;

    logic ld1_c, ld2_c, ld3_c;

    logic [N-1:0]  mag_a_c;
    logic [M-1:0]  mag_b_c;
    logic [LA-1:0] k1_c;
    logic [LB-1:0] k2_c;

    trunc_t           ta_c, tb_c;
    logic             small_c, zero_c;
    logic [N+M-1:0]   mag_c;

    // A slot may load when it is empty or its contents move on this cycle
    assign ld3_c        = !s3_v || bus.out_ready;
    assign ld2_c        = !s2_v || ld3_c;
    assign ld1_c        = !s1_v || ld2_c;
    assign bus.in_ready = ld1_c;

    // S1: magnitudes; the most negative value maps to 2^(W-1) as an unsigned magnitude
    assign mag_a_c = (bus.signed_mode && bus.a[N-1]) ? (~bus.a) + N'(1) : bus.a;
    assign mag_b_c = (bus.signed_mode && bus.b[M-1]) ? (~bus.b) + M'(1) : bus.b;

    drum_lod_enc #(.W(N)) u_lod_a (.x(mag_a_c), .pos_c(k1_c));
    drum_lod_enc #(.W(M)) u_lod_b (.x(mag_b_c), .pos_c(k2_c));

    always_comb begin
        s1_c       = '0;
        s1_c.mag_a = mag_a_c;
        s1_c.mag_b = mag_b_c;
        s1_c.sign  = (bus.a[N-1] ^ bus.b[M-1]) & bus.signed_mode;
        s1_c.k1    = k1_c;
        s1_c.k2    = k2_c;
    end

    // S2: truncate both operands, K x K core multiply
    assign ta_c    = drum_trunc(MW'(s1_q.mag_a), LW'(s1_q.k1));
    assign tb_c    = drum_trunc(MW'(s1_q.mag_b), LW'(s1_q.k2));
    assign small_c = (s1_q.k1 <= LA'(K - 1)) && (s1_q.k2 <= LB'(K - 1));
    // A zero operand yields the true product 0 regardless of the other operand
    assign zero_c  = (s1_q.mag_a == '0) || (s1_q.mag_b == '0);

    always_comb begin
        s2_c       = '0;
        s2_c.prod  = PW2'(ta_c.mm) * PW2'(tb_c.mm);
        s2_c.sh    = ta_c.p + tb_c.p;
        s2_c.sign  = s1_q.sign;
        s2_c.exact = small_c || zero_c;
    end

    // S3: restore magnitude scale and apply sign
    assign mag_c = (N + M)'(s2_q.prod) << s2_q.sh;

    always_comb begin
        s3_c       = '0;
        s3_c.r     = s2_q.sign ? ((N + M)'(0) - mag_c) : mag_c;
        s3_c.exact = s2_q.exact;
    end

    // Stage registers: valid bits follow the load enables, payloads load only with valid data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (ld1_c) begin
                s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= s1_c;
                end
            end
            if (ld2_c) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_q <= s2_c;
                end
            end
            if (ld3_c) begin
                s3_v <= s2_v;
                if (s2_v) begin
                    s3_q <= s3_c;
                end
            end
        end
    end

    assign bus.out_valid = s3_v;
    assign bus.r         = s3_q.r;
    assign bus.exact     = s3_q.exact;

endmodule

// File: tb/tb_drum_pipe_mult.sv
// Scoreboard bench for drum_pipe_mult (K=6, N=M=16).
module tb_drum_pipe_mult;

    localparam int unsigned K = 6;
    localparam int unsigned N = 16;
    localparam int unsigned M = 16;

    typedef struct {
        logic [31:0] r;
        logic        exact;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int   n_checks = 0;
    int   n_errors = 0;

    exp_t sb[$];
    bit   head_seen = 1'b0;
    bit   rand_run  = 1'b0;

    drum_pipe_mult_if #(.N(N), .M(M)) bus ();

    drum_pipe_mult #(.K(K), .N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: DRUM keeps the top K bits of each magnitude with the lowest
    // kept bit forced to 1, then multiplies the rescaled approximations.
    function automatic longint unsigned approx(input longint unsigned x);
        int msb;
        int p;
        if (x < 64'(1 << K)) return x;
        msb = 0;
        for (int i = 0; i < 64; i++) if (x[i]) msb = i;
        p = msb - (K - 1);
        return ((x >> p) | 64'd1) << p;
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sm);
        exp_t              e;
        longint unsigned   ma, mb, prod;
        longint            res;
        bit                neg;
        ma   = (sm && a[15]) ? 64'(65536 - int'(a)) : 64'(a);
        mb   = (sm && b[15]) ? 64'(65536 - int'(b)) : 64'(b);
        neg  = sm && (a[15] ^ b[15]);
        prod = approx(ma) * approx(mb);
        res  = neg ? -longint'(prod) : longint'(prod);
        e.r     = res[31:0];
        e.exact = (ma < 64 && mb < 64) || ma == 0 || mb == 0;
        e.acc   = 0;
        e.lat   = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] r, input logic exact);
        exp_t e;
        e.r = r; e.exact = exact; e.acc = 0; e.lat = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'($urandom_range(0, 63));
            default: return 16'($urandom);
        endcase
    endfunction

    // Offer one operand pair until accepted; expectation is queued at acceptance
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sm, input exp_t e);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = sm;
        #1;
        while (!bus.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
            #1;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'(0), 64'(1));
            bus.in_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        check("drain_left", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: compare the presented result against the queue head every valid cycle
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'(1), 64'(0));
                end else begin
                    check("r", 64'(bus.r), 64'(sb[0].r));
                    check("exact", 64'(bus.exact), 64'(sb[0].exact));
                    if (sb[0].lat && !head_seen)
                        check("latency", 64'(cyc), 64'(sb[0].acc + 3));
                    head_seen = 1'b1;
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int   acc_n;
        exp_t e;
        logic [15:0] ra, rb;
        logic        rs;

        bus.in_valid    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.out_ready   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_r", 64'(bus.r), 64'(0));
        check("rst_exact", 64'(bus.exact), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed values, back to back with no stall
        send(16'd25,   16'd40,   1'b0, mk(32'h000003E8, 1'b1));
        send(16'd1000, 16'd3,    1'b0, mk(32'h00000BD0, 1'b0));
        send(16'hFFFF, 16'hFFFF, 1'b0, mk(32'hF8100000, 1'b0));
        send(16'hFFE7, 16'd40,   1'b1, mk(32'hFFFFFC18, 1'b1));
        send(16'h8000, 16'd1,    1'b1, mk(32'hFFFF7C00, 1'b0));
        send(16'h0000, 16'd5,    1'b1, mk(32'h00000000, 1'b1));
        idle();
        wait_drain();

        // Backpressure: 8 pairs, out_ready low for cycles 4..9
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = rnd_op(); rb = rnd_op(); rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, model(ra, rb, rs));
                end
                idle();
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    bus.out_ready = !(c >= 4 && c <= 9);
                    if (c == 9) begin
                        #2;
                        check("bp_in_ready", 64'(bus.in_ready), 64'(0));
                        check("bp_in_flight", 64'(sb.size()), 64'(3));
                    end
                end
            end
        join
        wait_drain();

        // Randomized stream with random output stalls and input gaps
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    ra = rnd_op(); rb = rnd_op(); rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, model(ra, rb, rs));
                end
                idle();
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(negedge clk);
        bus.out_ready = 1'b1;
        wait_drain();

        // Fill the pipe with the output stalled: exactly 3 accepted
        @(negedge clk);
        bus.out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra = rnd_op(); rb = rnd_op(); rs = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1; bus.a = ra; bus.b = rb; bus.signed_mode = rs;
            #1;
            if (bus.in_ready) begin
                e = model(ra, rb, rs);
                e.acc = cyc;
                sb.push_back(e);
                acc_n++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("fill_accepts", 64'(acc_n), 64'(3));
        check("fill_in_ready", 64'(bus.in_ready), 64'(0));

        // Reset with 3 in flight: outputs clear at once, nothing stale afterwards
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_r", 64'(bus.r), 64'(0));
        check("midrst_exact", 64'(bus.exact), 64'(0));
        sb.delete();
        head_seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        send(16'd7, 16'd9, 1'b0, mk(32'd63, 1'b1));
        idle();
        wait_drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
